// File: rtl/int_nest_ctrl.sv
// -----------------------------------------------------------------------------
// int_nest_ctrl
//
// Nested interrupt entry/return controller. At instruction boundaries it
// decides whether to take the sampled interrupt request. When it takes one,
// it redirects the PC to a per-source vector and saves the return PC and the
// previous priority level on a small nesting stack. ERET pops the stack and
// restores the previous level.
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   synchronous active-low reset
//   Int          in   1   masked request present (from sampler)
//   Int_No       in   3   highest pending source (3 highest, 1 lowest, 0 none)
//   insn_done    in   1   instruction retires this cycle (entry/return point)
//   next_pc      in  32   PC of next instruction, valid with insn_done
//   eret         in   1   retiring instruction is ERET
//   ie_set       in   1   EI retiring
//   ie_clr       in   1   DI retiring
//   IE           out  1   global interrupt enable
//   INM          out  3   per-source mask, INM[i]=1 iff (i+1) <= cur_level
//   CLR          out  3   one-hot one-cycle clear pulse for serviced source
//   pc_redirect  out  1   CPU loads redirect_pc this cycle
//   redirect_pc  out 32   vector or return address
//   cur_level    out  2   priority level in service (0 = none)
//   stack_err    out  1   sticky: ERET underflow or push while full
// -----------------------------------------------------------------------------
module int_nest_ctrl #(
    parameter int          DEPTH = 3,
    parameter logic [31:0] VEC1  = 32'h0000_1000,
    parameter logic [31:0] VEC2  = 32'h0000_1100,
    parameter logic [31:0] VEC3  = 32'h0000_1200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Int,
    input  logic [2:0]  Int_No,
    input  logic        insn_done,
    input  logic [31:0] next_pc,
    input  logic        eret,
    input  logic        ie_set,
    input  logic        ie_clr,
    output logic        IE,
    output logic [2:0]  INM,
    output logic [2:0]  CLR,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic [1:0]  cur_level,
    output logic        stack_err
);

    localparam int            DW        = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TAKE = 2'd1,
        ST_RET  = 2'd2
    } state_t;

    state_t        state_r;
    logic [DW-1:0] depth_r;
    logic [31:0]   epc_r     [DEPTH];
    logic [1:0]    lvl_stk_r [DEPTH];

    logic          ie_r;
    logic [2:0]    inm_r;
    logic [2:0]    clr_r;
    logic          pc_redirect_r;
    logic [31:0]   redirect_pc_r;
    logic [1:0]    cur_level_r;
    logic          stack_err_r;

    logic          boundary_s;
    logic          req_valid_s;
    logic          ret_s;
    logic          ret_err_s;
    logic          take_s;
    logic          take_err_s;
    logic          ie_upd_s;
    logic [DW-1:0] top_s;

    // Mask of all sources at or below the given level (thermometer code).
    function automatic logic [2:0] level_mask(input logic [1:0] lvl);
        logic [2:0] m;
        case (lvl)
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b011;
            2'd3:    m = 3'b111;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    // Handler address for a source number; non-sources map to zero.
    function automatic logic [31:0] vec_addr(input logic [2:0] no);
        logic [31:0] a;
        case (no)
            3'd1:    a = VEC1;
            3'd2:    a = VEC2;
            3'd3:    a = VEC3;
            default: a = 32'h0000_0000;
        endcase
        return a;
    endfunction

    // One-hot clear pulse for the serviced source.
    function automatic logic [2:0] clr_onehot(input logic [2:0] no);
        logic [2:0] c;
        case (no)
            3'd1:    c = 3'b001;
            3'd2:    c = 3'b010;
            3'd3:    c = 3'b100;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    // Boundary decision: classify the retiring instruction into return,
    // underflow, entry, overflow or plain IE update (in that priority).
    always_comb begin
        boundary_s  = 1'b0;
        req_valid_s = 1'b0;
        ret_s       = 1'b0;
        ret_err_s   = 1'b0;
        take_s      = 1'b0;
        take_err_s  = 1'b0;
        ie_upd_s    = 1'b0;
        top_s       = depth_r - {{(DW-1){1'b0}}, 1'b1};

        if (state_r == ST_RUN) begin
            boundary_s = insn_done;
        end else begin
            boundary_s = 1'b0;
        end

        // Int_No outside 1..3 (including 0) is never a request.
        if (Int && ie_r && (Int_No >= 3'd1) && (Int_No <= 3'd3) &&
            (Int_No > {1'b0, cur_level_r})) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end

        if (boundary_s) begin
            if (eret) begin
                if (depth_r != {DW{1'b0}}) begin
                    ret_s = 1'b1;
                end else begin
                    ret_err_s = 1'b1;
                end
            end else if (req_valid_s) begin
                if (depth_r != DEPTH_MAX) begin
                    take_s = 1'b1;
                end else begin
                    take_err_s = 1'b1;
                end
            end else begin
                ie_upd_s = 1'b1;
            end
        end else begin
            ie_upd_s = 1'b0;
        end
    end

    // Nesting stack storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (take_s) begin
            epc_r[depth_r]     <= next_pc;
            lvl_stk_r[depth_r] <= cur_level_r;
        end
    end

    // Control FSM with all externally visible registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            depth_r       <= {DW{1'b0}};
            ie_r          <= 1'b0;
            inm_r         <= 3'b000;
            clr_r         <= 3'b000;
            pc_redirect_r <= 1'b0;
            redirect_pc_r <= 32'h0000_0000;
            cur_level_r   <= 2'd0;
            stack_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    clr_r         <= 3'b000;
                    pc_redirect_r <= 1'b0;
                    if (ret_s) begin
                        redirect_pc_r <= epc_r[top_s];
                        cur_level_r   <= lvl_stk_r[top_s];
                        inm_r         <= level_mask(lvl_stk_r[top_s]);
                        depth_r       <= top_s;
                        ie_r          <= 1'b1;
                        pc_redirect_r <= 1'b1;
                        state_r       <= ST_RET;
                    end else if (take_s) begin
                        redirect_pc_r <= vec_addr(Int_No);
                        clr_r         <= clr_onehot(Int_No);
                        cur_level_r   <= Int_No[1:0];
                        inm_r         <= level_mask(Int_No[1:0]);
                        depth_r       <= depth_r + {{(DW-1){1'b0}}, 1'b1};
                        ie_r          <= 1'b0;
                        pc_redirect_r <= 1'b1;
                        state_r       <= ST_TAKE;
                    end else if (ret_err_s || take_err_s) begin
                        stack_err_r <= 1'b1;
                    end else if (ie_upd_s) begin
                        // DI wins over EI when both retire together.
                        if (ie_clr) begin
                            ie_r <= 1'b0;
                        end else if (ie_set) begin
                            ie_r <= 1'b1;
                        end
                    end
                end
                ST_TAKE, ST_RET: begin
                    // Redirect and clear pulse last exactly one cycle.
                    clr_r         <= 3'b000;
                    pc_redirect_r <= 1'b0;
                    state_r       <= ST_RUN;
                end
                default: begin
                    clr_r         <= 3'b000;
                    pc_redirect_r <= 1'b0;
                    state_r       <= ST_RUN;
                end
            endcase
        end
    end

    assign IE          = ie_r;
    assign INM         = inm_r;
    assign CLR         = clr_r;
    assign pc_redirect = pc_redirect_r;
    assign redirect_pc = redirect_pc_r;
    assign cur_level   = cur_level_r;
    assign stack_err   = stack_err_r;

endmodule

// File: tb/tb_int_nest_ctrl.sv
module tb_int_nest_ctrl;

    logic        clk;
    logic        rst_n;
    logic        Int;
    logic [2:0]  Int_No;
    logic        insn_done;
    logic [31:0] next_pc;
    logic        eret;
    logic        ie_set;
    logic        ie_clr;
    logic        IE;
    logic [2:0]  INM;
    logic [2:0]  CLR;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  cur_level;
    logic        stack_err;

    int n_tests;
    int n_fail;

    int_nest_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Int         (Int),
        .Int_No      (Int_No),
        .insn_done   (insn_done),
        .next_pc     (next_pc),
        .eret        (eret),
        .ie_set      (ie_set),
        .ie_clr      (ie_clr),
        .IE          (IE),
        .INM         (INM),
        .CLR         (CLR),
        .pc_redirect (pc_redirect),
        .redirect_pc (redirect_pc),
        .cur_level   (cur_level),
        .stack_err   (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        intr;
        logic [2:0]  int_no;
        logic        done;
        logic [31:0] npc;
        logic        eret;
        logic        ie_set;
        logic        ie_clr;
        logic        e_ie;
        logic [2:0]  e_inm;
        logic [2:0]  e_clr;
        logic        e_pcr;
        logic [31:0] e_rpc;
        logic [1:0]  e_lvl;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    typedef struct {
        logic [31:0] pc;
        int          lvl;
    } frame_t;

    // reference model state
    frame_t      m_stk[$];
    int          m_level;
    logic        m_ie;
    logic        m_err;
    logic        m_pcr;
    logic [2:0]  m_clr;
    logic [31:0] m_rpc;
    logic        m_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_ie, input logic [2:0] e_inm,
                           input logic [2:0] e_clr, input logic e_pcr, input logic [31:0] e_rpc,
                           input logic [1:0] e_lvl, input logic e_err);
        chk({tag, ".IE"},          {31'd0, IE},          {31'd0, e_ie});
        chk({tag, ".INM"},         {29'd0, INM},         {29'd0, e_inm});
        chk({tag, ".CLR"},         {29'd0, CLR},         {29'd0, e_clr});
        chk({tag, ".pc_redirect"}, {31'd0, pc_redirect}, {31'd0, e_pcr});
        chk({tag, ".redirect_pc"}, redirect_pc,          e_rpc);
        chk({tag, ".cur_level"},   {30'd0, cur_level},   {30'd0, e_lvl});
        chk({tag, ".stack_err"},   {31'd0, stack_err},   {31'd0, e_err});
    endtask

    task automatic add(input logic r, input logic i, input logic [2:0] no, input logic d,
                       input logic [31:0] pc, input logic er, input logic s, input logic c,
                       input logic e_ie, input logic [2:0] e_inm, input logic [2:0] e_clr,
                       input logic e_pcr, input logic [31:0] e_rpc, input logic [1:0] e_lvl,
                       input logic e_err);
        vec_t v;
        v.rst_n = r;  v.intr = i; v.int_no = no; v.done = d; v.npc = pc;
        v.eret = er;  v.ie_set = s; v.ie_clr = c;
        v.e_ie = e_ie; v.e_inm = e_inm; v.e_clr = e_clr; v.e_pcr = e_pcr;
        v.e_rpc = e_rpc; v.e_lvl = e_lvl; v.e_err = e_err;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic i, input logic [2:0] no, input logic d,
                         input logic [31:0] pc, input logic er, input logic s, input logic c);
        rst_n = r; Int = i; Int_No = no; insn_done = d; next_pc = pc;
        eret = er; ie_set = s; ie_clr = c;
    endtask

    // Behavioural reference: one boundary decision per rising edge.
    task automatic model_step();
        frame_t f;
        if (!rst_n) begin
            m_stk.delete();
            m_level = 0; m_ie = 1'b0; m_err = 1'b0; m_pcr = 1'b0;
            m_clr = 3'b000; m_rpc = 32'h0; m_busy = 1'b0;
        end else if (m_busy) begin
            m_busy = 1'b0; m_pcr = 1'b0; m_clr = 3'b000;
        end else begin
            m_pcr = 1'b0; m_clr = 3'b000;
            if (insn_done) begin
                if (eret) begin
                    if (m_stk.size() > 0) begin
                        f = m_stk.pop_back();
                        m_rpc = f.pc; m_level = f.lvl; m_ie = 1'b1;
                        m_pcr = 1'b1; m_busy = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end else if (Int && m_ie && int'(Int_No) >= 1 && int'(Int_No) <= 3 &&
                             int'(Int_No) > m_level) begin
                    if (m_stk.size() < 3) begin
                        f.pc = next_pc; f.lvl = m_level;
                        m_stk.push_back(f);
                        m_rpc = 32'h0000_1000 + 32'h100 * (Int_No - 3'd1);
                        m_clr = 3'(1 << (Int_No - 3'd1));
                        m_level = int'(Int_No); m_ie = 1'b0;
                        m_pcr = 1'b1; m_busy = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end else if (ie_clr) begin
                    m_ie = 1'b0;
                end else if (ie_set) begin
                    m_ie = 1'b1;
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        drive(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        //   rst i  no   done pc             eret set clr | ie inm     clr     pcr rpc            lvl   err
        add(1'b0, 1'b0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0,         2'd0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 32'h0,         2'd0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 32'h0,         2'd0, 1'b0);
        add(1'b1, 1'b1, 3'd2, 1'b1, 32'h0000_0040,1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 3'b010, 1'b1, 32'h0000_1100, 2'd2, 1'b0);
        add(1'b1, 1'b1, 3'd2, 1'b1, 32'h0000_0099,1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 3'b000, 1'b0, 32'h0000_1100, 2'd2, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b1, 32'h0000_1104,1'b0, 1'b1, 1'b0, 1'b1, 3'b011, 3'b000, 1'b0, 32'h0000_1100, 2'd2, 1'b0);
        add(1'b1, 1'b1, 3'd1, 1'b1, 32'h0000_1106,1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 3'b000, 1'b0, 32'h0000_1100, 2'd2, 1'b0);
        add(1'b1, 1'b1, 3'd3, 1'b1, 32'h0000_1108,1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b100, 1'b1, 32'h0000_1200, 2'd3, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 32'h0000_1200, 2'd3, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b1, 32'h0000_1210,1'b1, 1'b0, 1'b0, 1'b1, 3'b011, 3'b000, 1'b1, 32'h0000_1108, 2'd2, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 3'b000, 1'b0, 32'h0000_1108, 2'd2, 1'b0);
        add(1'b1, 1'b1, 3'd3, 1'b1, 32'h0000_1120,1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b1, 32'h0000_0040, 2'd0, 1'b0);
        add(1'b1, 1'b1, 3'd3, 1'b1, 32'h0000_0040,1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 32'h0000_0040, 2'd0, 1'b0);
        add(1'b1, 1'b1, 3'd3, 1'b1, 32'h0000_0044,1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b100, 1'b1, 32'h0000_1200, 2'd3, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 32'h0000_1200, 2'd3, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b1, 32'h0000_1204,1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b1, 32'h0000_0044, 2'd0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 32'h0000_0044, 2'd0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b1, 32'h0000_0048,1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 32'h0000_0044, 2'd0, 1'b1);
        add(1'b1, 1'b0, 3'd0, 1'b1, 32'h0000_004C,1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0000_0044, 2'd0, 1'b1);
        add(1'b1, 1'b1, 3'd0, 1'b1, 32'h0000_0050,1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 32'h0000_0044, 2'd0, 1'b1);

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].rst_n, tbl[k].intr, tbl[k].int_no, tbl[k].done, tbl[k].npc,
                  tbl[k].eret, tbl[k].ie_set, tbl[k].ie_clr);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", k), tbl[k].e_ie, tbl[k].e_inm, tbl[k].e_clr,
                    tbl[k].e_pcr, tbl[k].e_rpc, tbl[k].e_lvl, tbl[k].e_err);
        end

        // Reset arriving while TAKE is in progress abandons the redirect.
        drive(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'd0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 3'd1, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_all("take1", 1'b0, 3'b001, 3'b001, 1'b1, 32'h0000_1000, 2'd1, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_all("rst_in_take", 1'b0, 3'b000, 3'b000, 1'b0, 32'h0, 2'd0, 1'b0);

        // Randomized run against the reference model.
        drive(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        model_step();
        #1;
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 1) == 1),
                  3'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 6),
                  $urandom,
                  ($urandom_range(0, 9) < 2),
                  ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 9) < 1));
            @(posedge clk);
            model_step();
            #1;
            chk_all($sformatf("rnd%0d", n), m_ie, 3'((1 << m_level) - 1), m_clr, m_pcr,
                    m_rpc, 2'(m_level), m_err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
